instr_encoder: RTL
==================

# instr_encoder

Streaming RV32I instruction encoder: accepts decoded operations (cuOP, register indices, immediate) in the control unit's field format and emits 32-bit RV32I instruction words with a target word address. It is the inverse of the control decoder. It sits between the test-program generator / program loader and instruction memory, and supports round-trip checks of the decoder. The block is one registered pipeline stage with a valid/ready handshake on each side, an address counter and an error counter.

## Interface
- BASE_ADDR, 32'h0000_0000, first word address after reset or clear
- clk  input  1  rising-edge clock
- nrst  input  1  synchronous reset, active-low
- clear  input  1  synchronous restart: address to BASE_ADDR, output slot emptied, err_count kept
- in_valid  input  1  operation present on in_* fields
- in_ready  output  1  encoder accepts the operation this cycle
- in_cuop  input  6  operation code, decoder enumeration: LUI=0, AUIPC=1, JAL=2, JALR=3, BEQ..BGEU=4..9, LB,LH,LW,LBU,LHU=10..14, SB,SH,SW=15..17, ADDI=18, SLTI=19, SLTIU=20, (21 unused), XORI=22, ORI=23, ANDI=24, SLLI=25, SRLI=26, SRAI=27, ADD=28, SUB=29, SLL=30, SLT=31, SLTU=32, XOR=33, SRL=34, SRA=35, OR=36, AND=37
- in_rd, in_rs1, in_rs2  input  5 each  register indices
- in_imm  input  20  immediate in decoder packing: U/J raw instr[31:12]; I/S/B in low 12 bits
- out_valid  output  1  out_instr/out_addr hold a word
- out_ready  input  1  consumer takes the word
- out_instr  output  32  encoded instruction
- out_addr  output  32  word address for out_instr
- err  output  1  one-cycle pulse when an illegal cuOP is accepted
- err_count  output  8  saturating count of illegal cuOPs

## Operation
- in_ready = !out_valid || out_ready (one-entry pipeline, full throughput).
- Accept when in_valid && in_ready. For a legal cuOP, the encoded word loads the output register and out_valid goes to 1.
- Illegal cuOP (21, or 38..63): the operation is consumed and no word is produced. err pulses on the next cycle and err_count increments, saturating at 255. out_valid is 0 next cycle unless a held word remains; a held word cannot remain, because acceptance requires an empty slot or a drain.
- Encoding follows the RV32I base ISA:
  - opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, branch 1100011, load 0000011, store 0100011, OP-IMM 0010011, OP 0110011.
  - funct3 per ISA.
  - U/J types: instr[31:12]=in_imm, instr[11:7]=rd.
  - I type (JALR, loads, OP-IMM): instr[31:20]=in_imm[11:0], rs1, rd.
  - S/B types: instr[31:25]=in_imm[11:5], instr[11:7]=in_imm[4:0], rs1, rs2.
  - SLLI/SRLI: instr[31:25]=0000000. SRAI: instr[31:25]=0100000. All three use instr[24:20]=in_imm[4:0]; in_imm[11:5] is ignored.
  - R type: funct7=0100000 for SUB/SRA, else 0000000.
- Fields unused by a format (e.g. rs2 for I type) do not affect out_instr.
- Address counter:
  - out_addr is the address of the word in the slot.
  - It advances by 4 on each output handshake (out_valid && out_ready) and wraps modulo 2^32.
  - Illegal ops do not consume an address.

## Timing
- Reset (nrst=0 at clock edge): out_valid=0, out_instr=0, out_addr=BASE_ADDR, err=0, err_count=0. in_ready is 1 in the cycle after reset.
- Latency: accept in cycle N gives out_valid=1 in cycle N+1.
- Back-to-back: with out_ready held at 1, one word per cycle.
- Hold: out_instr and out_addr are stable while out_valid && !out_ready.
- Simultaneous output handshake and input accept: the new word replaces the old one and out_addr advances by 4 in the same edge.
- Simultaneous output handshake and illegal accept: out_valid drops to 0, out_addr advances, err pulses.
- clear and nrst=0 both override any handshake in that cycle; nrst has priority over clear.
- Reset mid-stream: the held word is discarded without handshake.

## Test plan
- Reset, then ADDI rd=5, rs1=0, imm=12'h001 -> next cycle out_valid=1, out_instr=32'h00100293, out_addr=BASE_ADDR.
- Stream of 4 legal ops with out_ready=1 -> 4 consecutive words, addresses BASE, +4, +8, +12. Words include:
  - SUB x3,x1,x2 = 32'h402081B3
  - SW x2,8(x1) = 32'h0020A423
  - SRAI x1,x1,3 = 32'h4030D093
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_instr/out_addr unchanged; release -> one word per cycle resumes with no loss or duplication.
- Illegal cuOP 21 then 40 between legal ops -> two err pulses, err_count=2, no gap in out_addr.
- 256+ illegal ops -> err_count saturates at 255.
- clear asserted with a held word -> out_valid=0, next word lands at BASE_ADDR. Random legal ops fed through control decoder -> decoded fields match the input fields for all non-shift ops.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: turns decoded control-unit operations (cuOP, register
// indices, packed immediate) back into 32-bit RV32I instruction words.
// One registered output slot with valid/ready on both sides, a word
// address counter for the slot and a saturating illegal-op counter.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_cuop,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [19:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [7:0]  err_count
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        accept;
  logic        out_hs;

  assign in_ready  = !valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_hs    = valid_q && out_ready;
  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_addr  = addr_q;
  assign err       = err_q;
  assign err_count = cnt_q;

  // Map the cuOP to its RV32I format, opcode and funct3/funct7, then assemble the word.
  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    case (in_cuop)
      6'd0: enc_word = {in_imm, in_rd, OPC_LUI};
      6'd1: enc_word = {in_imm, in_rd, OPC_AUIPC};
      6'd2: enc_word = {in_imm, in_rd, OPC_JAL};
      6'd3: enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR};
      6'd4: enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b000, in_imm[4:0], OPC_BRANCH};
      6'd5: enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b001, in_imm[4:0], OPC_BRANCH};
      6'd6: enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b100, in_imm[4:0], OPC_BRANCH};
      6'd7: enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b101, in_imm[4:0], OPC_BRANCH};
      6'd8: enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b110, in_imm[4:0], OPC_BRANCH};
      6'd9: enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b111, in_imm[4:0], OPC_BRANCH};
      6'd10: enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_LOAD};
      6'd11: enc_word = {in_imm[11:0], in_rs1, 3'b001, in_rd, OPC_LOAD};
      6'd12: enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, OPC_LOAD};
      6'd13: enc_word = {in_imm[11:0], in_rs1, 3'b100, in_rd, OPC_LOAD};
      6'd14: enc_word = {in_imm[11:0], in_rs1, 3'b101, in_rd, OPC_LOAD};
      6'd15: enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b000, in_imm[4:0], OPC_STORE};
      6'd16: enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b001, in_imm[4:0], OPC_STORE};
      6'd17: enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OPC_STORE};
      6'd18: enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_OPIMM};
      6'd19: enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, OPC_OPIMM};
      6'd20: enc_word = {in_imm[11:0], in_rs1, 3'b011, in_rd, OPC_OPIMM};
      6'd22: enc_word = {in_imm[11:0], in_rs1, 3'b100, in_rd, OPC_OPIMM};
      6'd23: enc_word = {in_imm[11:0], in_rs1, 3'b110, in_rd, OPC_OPIMM};
      6'd24: enc_word = {in_imm[11:0], in_rs1, 3'b111, in_rd, OPC_OPIMM};
      6'd25: enc_word = {7'b0000000, in_imm[4:0], in_rs1, 3'b001, in_rd, OPC_OPIMM};
      6'd26: enc_word = {7'b0000000, in_imm[4:0], in_rs1, 3'b101, in_rd, OPC_OPIMM};
      6'd27: enc_word = {7'b0100000, in_imm[4:0], in_rs1, 3'b101, in_rd, OPC_OPIMM};
      6'd28: enc_word = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OPC_OP};
      6'd29: enc_word = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, OPC_OP};
      6'd30: enc_word = {7'b0000000, in_rs2, in_rs1, 3'b001, in_rd, OPC_OP};
      6'd31: enc_word = {7'b0000000, in_rs2, in_rs1, 3'b010, in_rd, OPC_OP};
      6'd32: enc_word = {7'b0000000, in_rs2, in_rs1, 3'b011, in_rd, OPC_OP};
      6'd33: enc_word = {7'b0000000, in_rs2, in_rs1, 3'b100, in_rd, OPC_OP};
      6'd34: enc_word = {7'b0000000, in_rs2, in_rs1, 3'b101, in_rd, OPC_OP};
      6'd35: enc_word = {7'b0100000, in_rs2, in_rs1, 3'b101, in_rd, OPC_OP};
      6'd36: enc_word = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, OPC_OP};
      6'd37: enc_word = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, OPC_OP};
      default: enc_legal = 1'b0;
    endcase
  end

  // Next-state for the slot, address counter and error bookkeeping.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    if (clear) begin
      valid_d = 1'b0;
      addr_d  = BASE_ADDR;
    end else begin
      if (out_hs) begin
        valid_d = 1'b0;
        addr_d  = addr_q + 32'd4;
      end
      if (accept) begin
        if (enc_legal) begin
          valid_d = 1'b1;
          instr_d = enc_word;
        end else begin
          err_d = 1'b1;
          if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
    end
  end

  // Register stage with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      addr_q  <= BASE_ADDR;
      err_q   <= 1'b0;
      cnt_q   <= 8'h0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
